dec_scan: RTL
=============

DEC_SCAN -- requirements
Module: dec_scan

Interface
REQ-001 SHALL provide parameter N, default 4, meaning index width; legal range 1..8.
REQ-002 SHALL provide parameter DWELL, default 4, meaning clock cycles spent on each index in scan modes; legal range 1..65535.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL provide port en  input  1  block enable.
REQ-006 SHALL provide port mode  input  2  00 direct, 01 scan-up, 10 scan-down, 11 hold.
REQ-007 SHALL provide port in_valid  input  1  direct-mode load request.
REQ-008 SHALL provide port in_idx  input  N  index to load.
REQ-009 SHALL provide port in_ready  output  1  load accepted this cycle when high together with in_valid.
REQ-010 SHALL provide port out  output  2**N  registered one-hot decode of the current index.
REQ-011 SHALL provide port idx  output  N  current index register.
REQ-012 SHALL provide port wrap  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-013 in_ready SHALL be combinational: high iff rst low, en high and mode == 00.
REQ-014 Direct: when in_valid && in_ready, idx SHALL load in_idx at that edge; out SHALL show 1 << in_idx from the same edge (1-cycle latency from acceptance).
REQ-015 Direct with no accepted load SHALL hold idx unchanged.
REQ-016 Scan: an internal dwell counter SHALL count 0..DWELL-1; when it is DWELL-1 with en high, idx SHALL step (+1 scan-up, -1 scan-down, modulo 2**N) and the counter SHALL return to 0.
REQ-017 DWELL == 1 SHALL step idx every enabled cycle.
REQ-018 wrap SHALL be high for exactly the cycle following a step from 2**N-1 to 0 (scan-up) or from 0 to 2**N-1 (scan-down), and low otherwise.
REQ-019 Hold: idx and the dwell counter SHALL be frozen; out SHALL continue to show 1 << idx.
REQ-020 Any change of mode between consecutive cycles SHALL clear the dwell counter to 0 at that edge; idx SHALL be retained.
REQ-021 en low SHALL freeze idx and the dwell counter and force in_ready low; out SHALL be all-zero from the next edge.
REQ-022 en rising SHALL restore out to 1 << idx at the next edge, with the dwell counter resuming from its frozen value.
REQ-023 out SHALL be registered: out <= en ? (1 << idx_next) : 0, so that exactly one bit is set whenever en was high at the last edge.
REQ-024 in_valid SHALL be ignored when in_ready is low, with no effect on state.
REQ-025 N == 1 SHALL yield a 2-bit output whose scan alternates between the two indices.

Reset
REQ-026 rst high SHALL immediately, without waiting for a clock edge, set idx=0, dwell counter=0, out=0, wrap=0.
REQ-027 in_ready SHALL be low while rst is high.
REQ-028 Reset asserted mid-dwell or mid-load SHALL discard all pending progress; after release, the first enabled edge SHALL produce out = 1 << 0 (direct/hold) or begin the dwell at count 0 (scan).

Verification
REQ-029 N=4, DWELL=3, mode=00, en=1: apply in_valid with in_idx=9 for one cycle -> next cycle idx=9, out=16'h0200, in_ready=1 throughout.
REQ-030 mode=01, en=1, idx=14: over 9 cycles -> idx goes 14,14,14,15,15,15,0,0,0 with wrap=1 only in the first cycle at idx=0, and out=16'h0001 during the idx=0 cycles.
REQ-031 mode=10, DWELL=1, idx=1 -> idx sequence 0,15,14 on consecutive cycles; wrap=1 only in the cycle showing idx=15.
REQ-032 mode=01, en dropped for 5 cycles mid-dwell (counter=1) -> out=0 and idx unchanged during the gap; after en returns, the step occurs 2 enabled cycles later.
REQ-033 mode=11, in_valid=1, in_idx=3 -> in_ready=0, idx and out unchanged; switching to mode=01 -> the first step occurs DWELL cycles later.
REQ-034 Assert rst asynchronously between edges during scan with idx=7 -> idx=0, out=0, wrap=0 immediately; after release with mode=00, en=1 -> out=16'h0001 at the next edge.

Source files
------------

// File: rtl/dec_scan.sv
// dec_scan: index register with a registered one-hot decoder and an optional
// dwell-timed scanner.
//
// Ports:
//   clk       single clock, rising edge
//   rst       asynchronous active-high reset
//   en        block enable; low freezes state and blanks out
//   mode      00 direct load, 01 scan-up, 10 scan-down, 11 hold
//   in_valid  direct-mode load request
//   in_idx    index to load
//   in_ready  combinational; load accepted when high together with in_valid
//   out       registered one-hot decode of the current index (zero when disabled)
//   idx       current index register
//   wrap      one-cycle pulse following a scan wrap-around
module dec_scan #(
  parameter int unsigned N     = 4,
  parameter int unsigned DWELL = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [1:0]     mode,
  input  logic           in_valid,
  input  logic [N-1:0]   in_idx,
  output logic           in_ready,
  output logic [2**N-1:0] out,
  output logic [N-1:0]   idx,
  output logic           wrap
);

  localparam logic [15:0] DwellMax = 16'(DWELL - 1);

  logic [N-1:0]    idx_q, idx_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2**N-1:0] out_q, out_d;
  logic            wrap_q, wrap_d;
  logic [1:0]      mode_q;
  logic            mode_chg;

  assign in_ready = ~rst & en & (mode == 2'b00);
  assign mode_chg = (mode != mode_q);

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    out_d  = '0;

    if (en) begin
      unique case (mode)
        2'b00: begin
          if (in_valid) idx_d = in_idx;
        end
        2'b01, 2'b10: begin
          // The edge that enters a scan mode only restarts the dwell.
          if (!mode_chg) begin
            if (cnt_q == DwellMax) begin
              cnt_d = '0;
              if (mode == 2'b01) begin
                idx_d  = idx_q + 1'b1;
                wrap_d = (idx_q == '1);
              end else begin
                idx_d  = idx_q - 1'b1;
                wrap_d = (idx_q == '0);
              end
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        2'b11: ;
        default: ;
      endcase
    end

    // Any mode change restarts the dwell, enabled or not.
    if (mode_chg) cnt_d = '0;

    if (en) out_d[idx_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      wrap_q <= 1'b0;
      mode_q <= 2'b00;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
      mode_q <= mode;
    end
  end

  assign idx  = idx_q;
  assign out  = out_q;
  assign wrap = wrap_q;

endmodule
